// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and constants for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_ADD         = 0;
  localparam int unsigned OP_SUB         = 1;
  localparam int unsigned OP_AND         = 2;
  localparam int unsigned OP_OR          = 3;
  localparam int unsigned OP_XOR         = 4;
  localparam int unsigned OP_NOR         = 5;
  localparam int unsigned OP_SLT         = 6;
  localparam int unsigned OP_SLTU        = 7;
  localparam int unsigned OP_MUL         = 8;
  localparam int unsigned OP_MULHU       = 9;
  localparam int unsigned OP_DIVU        = 10;
  localparam int unsigned OP_REMU        = 11;
  localparam int unsigned OP_ILLEGAL_MIN = 12;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  // Divide-by-zero quotient: all ones, sliced down to the instance width.
  localparam int unsigned          MAX_WIDTH = 128;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Multiply: {hi,lo} ends as a*b. Divide: lo ends as quotient, hi as remainder.
// The first iteration is taken on the start edge, so busy covers WIDTH-1 more edges.
module seq_alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_is_div;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_div;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;

  // Step source: fresh operands on start, otherwise the running state.
  assign w_div  = start ? is_div : r_is_div;
  assign w_opnd = start ? (is_div ? b : a) : r_opnd;
  assign w_hi   = start ? '0 : r_hi;
  assign w_lo   = start ? (is_div ? a : b) : r_lo;

  // Multiply step: conditional add of the multiplicand, then shift right.
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_opnd} : '0);

  // Divide step: shift in next dividend bit, trial-subtract the divisor.
  assign w_shift = {w_hi, w_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, w_opnd};
  assign w_qbit  = ~w_diff[WIDTH];

  // Select next accumulator halves for the active operation.
  always_comb begin
    w_nxt_hi = w_sum[WIDTH:1];
    w_nxt_lo = {w_sum[0], w_lo[WIDTH-1:1]};
    if (w_div) begin
      w_nxt_hi = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_nxt_lo = {w_lo[WIDTH-2:0], w_qbit};
    end
  end

  // Iteration state and counter; busy drops when the count hits zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (start) begin
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
      r_is_div <= is_div;
      r_opnd   <= w_opnd;
      r_hi     <= w_nxt_hi;
      r_lo     <= w_nxt_lo;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CW'(1);
      r_busy <= (r_cnt != CW'(1));
      r_hi   <= w_nxt_hi;
      r_lo   <= w_nxt_lo;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: legacy single-cycle ops plus iterative mul/div behind a
// valid/ready handshake, with registered result, zero and illegal-op flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_sel_hi;

  logic             w_op_mul;
  logic             w_op_div;
  logic             w_b_zero;
  logic             w_start;
  logic             w_illegal;
  logic [WIDTH-1:0] w_single;
  logic             w_busy;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_iter_res;

  assign w_op_mul  = (op == OPW'(OP_MUL)) || (op == OPW'(OP_MULHU));
  assign w_op_div  = (op == OPW'(OP_DIVU)) || (op == OPW'(OP_REMU));
  assign w_b_zero  = (src_b == '0);
  assign w_illegal = (op >= OPW'(OP_ILLEGAL_MIN));
  assign w_start   = (r_state == IDLE) && in_valid &&
                     (w_op_mul || (w_op_div && !w_b_zero));

  // Single-cycle results, including the divide-by-zero shortcut.
  always_comb begin
    w_single = '0;
    case (op)
      OPW'(OP_ADD):  w_single = src_a + src_b;
      OPW'(OP_SUB):  w_single = src_a - src_b;
      OPW'(OP_AND):  w_single = src_a & src_b;
      OPW'(OP_OR):   w_single = src_a | src_b;
      OPW'(OP_XOR):  w_single = src_a ^ src_b;
      OPW'(OP_NOR):  w_single = ~(src_a | src_b);
      OPW'(OP_SLT):  w_single = (src_a - src_b) >> (WIDTH - 1);
      OPW'(OP_SLTU): w_single = WIDTH'(src_a < src_b);
      OPW'(OP_DIVU): w_single = DIV0_QUOT[WIDTH-1:0];
      OPW'(OP_REMU): w_single = src_a;
      default:       w_single = '0;
    endcase
  end

  seq_alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .is_div (w_op_div),
    .a      (src_a),
    .b      (src_b),
    .busy   (w_busy),
    .lo     (w_lo),
    .hi     (w_hi)
  );

  assign w_iter_res = r_sel_hi ? w_hi : w_lo;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_sel_hi    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_sel_hi   <= (op == OPW'(OP_MULHU)) || (op == OPW'(OP_REMU));
            if (w_op_mul) begin
              r_state <= MUL;
            end else if (w_op_div && !w_b_zero) begin
              r_state <= DIV;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_single;
              r_zero      <= (w_single == '0);
              r_illegal   <= w_illegal;
            end
          end
        end
        MUL, DIV: begin
          if (!w_busy) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_iter_res;
            r_zero      <= (w_iter_res == '0);
            r_illegal   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32) with an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(32), .OPW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic from the op definitions.
  function automatic logic [31:0] m_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] d;
    p = {32'b0, a} * {32'b0, b};
    d = a - b;
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return {31'b0, d[31]};
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd8:    return p[31:0];
      4'd9:    return p[63:32];
      4'd10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int m_lat(input logic [3:0] o, input logic [31:0] b);
    if (o == 4'd8 || o == 4'd9) return 33;
    if ((o == 4'd10 || o == 4'd11) && b != 0) return 33;
    return 1;
  endfunction

  // Transaction-level model: pending op, edges left until result, expected outputs.
  logic        m_pend, m_done, m_ill;
  int          m_left;
  logic [31:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_ill  <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend <= 1'b1;
        m_res  <= m_alu(op, src_a, src_b);
        m_ill  <= (op >= 4'd12);
        m_left <= m_lat(op, src_b) - 1;
        m_done <= (m_lat(op, src_b) == 1);
      end
    end else if (!m_done) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (out_ready) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
    end
  end

  // Per-cycle compare of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_in_ready", {31'b0, in_ready}, {31'b0, !m_pend});
      chk("mon_out_valid", {31'b0, out_valid}, {31'b0, m_done});
      if (m_done) begin
        chk("mon_result", result, m_res);
        chk("mon_zero", {31'b0, zero}, {31'b0, (m_res == 32'd0)});
        chk("mon_illegal", {31'b0, illegal_op}, {31'b0, m_ill});
      end
    end
  end

  // Issue one op, measure accept-to-valid edges, check the literal result.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit consume);
    int edges;
    @(negedge clk);
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(edges), 32'(exp_lat));
    chk({nm, "_result"}, result, exp_res);
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_idle"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // Legacy single-cycle ops.
    run_op("sub_3_3",   4'd1, 32'd3, 32'd3, 32'd0, 1, 1'b1);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    run_op("nor_0_0",   4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run_op("slt_m1_1",  4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b1);
    run_op("sltu_m1_1", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1);
    run_op("add_wrap",  4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1);
    chk("add_wrap_zero", {31'b0, zero}, 32'd1);
    run_op("xor",       4'd4, 32'hF0F0_1234, 32'h0FF0_1230, 32'hFF00_0004, 1, 1'b1);

    // Multiply.
    run_op("mul_big",   4'd8, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, 1'b1);
    run_op("mulhu_big", 4'd9, 32'h0001_0000, 32'h0001_0000, 32'd1, 33, 1'b1);
    run_op("mul_7_6",   4'd8, 32'd7, 32'd6, 32'd42, 33, 1'b1);

    // Divide, including divide by zero.
    run_op("divu_100_7", 4'd10, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    run_op("remu_100_7", 4'd11, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    run_op("divu_5_0",   4'd10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run_op("remu_5_0",   4'd11, 32'd5, 32'd0, 32'd5, 1, 1'b1);

    // Backpressure: hold the result for 20 cycles while in_valid pulses.
    run_op("mul_bp", 4'd8, 32'd123, 32'd456, 32'd56088, 33, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = i[0];
      op = 4'd0;
      src_a = $urandom;
      src_b = $urandom;
    end
    in_valid = 1'b0;
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_result", result, 32'd56088);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);

    // Illegal op, then a legal op clears the flag.
    run_op("illegal_13", 4'd13, 32'd9, 32'd9, 32'd0, 1, 1'b0);
    chk("illegal_flag", {31'b0, illegal_op}, 32'd1);
    chk("illegal_zero", {31'b0, zero}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    run_op("add_1_1", 4'd0, 32'd1, 32'd1, 32'd2, 1, 1'b0);
    chk("add_1_1_illegal", {31'b0, illegal_op}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a divide.
    run_op("add_5_7_pre", 4'd0, 32'd5, 32'd7, 32'd12, 1, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_div_result", result, 32'd0);
    chk("arst_div_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_div_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    run_op("add_5_7_post", 4'd0, 32'd5, 32'd7, 32'd12, 1, 1'b1);

    // Asynchronous reset while holding a zero result in DONE.
    run_op("sub_hold", 4'd1, 32'd3, 32'd3, 32'd0, 1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_done_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_done_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the single-cycle ALU in the processor datapath.
- Keeps the eight existing single-cycle ops and their encodings.
- Adds iterative unsigned multiply and divide.
- Uses a valid/ready handshake so the multi-cycle datapath stalls on long ops.
- Registered result and Zero flag.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4).
OPW, 4, opcode width; ops 0-7 match the legacy 3-bit encoding zero-extended.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an op (high only in IDLE)
op  input  OPW  operation select
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
out_valid  output  1  result valid; held until consumed
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered: result == 0
illegal_op  output  1  registered: op code was 12-15

Behaviour:
- Op encoding:
  - 0 add; 1 sub; 2 and; 3 or; 4 xor; 5 nor.
  - 6 slt signed: result = {WIDTH-1 zeros, sign bit of A-B}. Keeps the legacy definition; no overflow correction.
  - 7 sltu: unsigned A<B, zero-extended.
  - 8 mul: low WIDTH bits of A*B.
  - 9 mulhu: high WIDTH bits of unsigned A*B.
  - 10 divu: unsigned quotient.
  - 11 remu: unsigned remainder.
  - 12-15 illegal: result 0, zero 1, illegal_op 1.
- All arithmetic is modulo 2^WIDTH; carries are discarded.
- Reset (async, any state, including mid-iteration):
  - state IDLE
  - out_valid 0, result 0, zero 0, illegal_op 0
  - internal counter, accumulators and operand registers cleared
- States:
  - IDLE: in_ready=1. Accept on in_valid. Ops 0-7 and 12-15 go to DONE next edge, with result captured at that edge (latency 1). Ops 8/9 go to MUL; ops 10/11 go to DIV. Operands are latched at acceptance; later src_a/src_b changes are ignored.
  - MUL: shift-add, one bit of B per cycle, 2*WIDTH-bit accumulator. Exactly WIDTH cycles in MUL, then DONE. Total latency from accept edge to out_valid = WIDTH+1 edges.
  - DIV: restoring division, one quotient bit per cycle. Exactly WIDTH cycles, then DONE.
    - Divide by zero (src_b==0 at accept) skips DIV and goes straight to DONE (latency 1): divu gives all ones, remu gives src_a.
  - DONE: out_valid=1; result, zero and illegal_op are stable. On out_ready go to IDLE next edge. out_valid stays high with constant outputs while out_ready=0.
- in_ready is 0 in MUL, DIV and DONE. in_valid in those states is ignored, not queued.
- Minimum throughput: one op per 2 cycles, because DONE→IDLE costs one edge even when out_ready is held high.
- Iteration counter: $clog2(WIDTH)+1 bits, loaded at accept, decremented per iteration. Leaving MUL/DIV triggers on count reaching terminal value, never on wrap.
- illegal_op never asserts for ops 0-11.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_REMU, OP_ILLEGAL_MIN=12)
  - state enum {IDLE, MUL, DIV, DONE}
  - the divide-by-zero quotient constant as a WIDTH-generic all-ones expression
- One sub-module: seq_alu_muldiv_iter.
  - Contents: iterative shift-add / restoring-divide datapath with counter.
  - Interface: start, is_div, a, b, busy, lo, hi.
  - Top keeps the FSM, the single-cycle ops and the output registers.

Test Plan:
- Reset: assert rst mid-DIV (cycle 10 of 32) → out_valid, result, zero drop to 0 immediately, without waiting for a clock edge; in_ready=1 after release; next op add 5+7 → result 12 after 1 edge.
- Legacy ops, WIDTH=32:
  - sub 3-3 → result 0, zero=1.
  - nor 0,0 → 0xFFFFFFFF.
  - slt 0xFFFFFFFF, 1 → 1.
  - sltu 0xFFFFFFFF, 1 → 0.
  - add 0xFFFFFFFF+1 → 0, zero=1.
- Multiply:
  - mul 0x10000 × 0x10000 → 0 after exactly 33 edges.
  - mulhu same operands → 0x00000001.
  - mul 7 × 6 → 42.
- Divide:
  - divu 100/7 → 14.
  - remu 100/7 → 2, 33-edge latency.
  - divu 5/0 → 0xFFFFFFFF after 1 edge.
  - remu 5/0 → 5.
- Backpressure: hold out_ready=0 for 20 cycles after mul done → out_valid and result stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → IDLE next edge.
- Illegal op 13 → result 0, zero=1, illegal_op=1. The following add 1+1 gives illegal_op=0, result 2.
